// File: rtl/memory_cycle_pkg.sv
// Shared types for the memory-access stage: access-size encodings, the
// stage FSM states and the size-to-byte-mask helpers.
package memory_pkg;

  // funct3 encodings of load/store size and signedness
  typedef enum logic [2:0] {
    MEM_B       = 3'b000,
    MEM_H       = 3'b001,
    MEM_W       = 3'b010,
    MEM_D       = 3'b011,
    MEM_BU      = 3'b100,
    MEM_HU      = 3'b101,
    MEM_WU      = 3'b110,
    MEM_ILLEGAL = 3'b111
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } mem_state_t;

  // Byte-enable pattern for an access of this size at offset 0
  function automatic logic [7:0] size_byte_mask(input mem_size_t size);
    logic [7:0] mask;
    case (size[1:0])
      2'd0:    mask = 8'h01;
      2'd1:    mask = 8'h03;
      2'd2:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

  // Offset bits that must be zero for a naturally aligned access
  function automatic logic [2:0] size_align_mask(input mem_size_t size);
    logic [2:0] mask;
    case (size[1:0])
      2'd0:    mask = 3'd0;
      2'd1:    mask = 3'd1;
      2'd2:    mask = 3'd3;
      default: mask = 3'd7;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/memory_cycle_if.sv
// Data-memory request/grant/response bus.
//   master: req, we, addr (word aligned), be, wdata out; gnt, rvalid, rdata in
//   slave : the mirror image
interface memory_cycle_if #(
  parameter int XLEN = 64
);
  logic              req;
  logic              we;
  logic [XLEN-1:0]   addr;
  logic [XLEN/8-1:0] be;
  logic [XLEN-1:0]   wdata;
  logic              gnt;
  logic              rvalid;
  logic [XLEN-1:0]   rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/memory_cycle_aligner.sv
// load_data_aligner: combinational load-data extraction.
//   rdata  : full memory word
//   offset : byte offset of the access within the word
//   funct3 : access size/sign
//   data   : selected bytes, sign- or zero-extended to XLEN
module load_data_aligner
  import memory_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0]           rdata,
  input  logic [$clog2(XLEN/8)-1:0] offset,
  input  mem_size_t                 funct3,
  output logic [XLEN-1:0]           data
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (funct3)
      MEM_B:   data = XLEN'($signed(shifted[7:0]));
      MEM_H:   data = XLEN'($signed(shifted[15:0]));
      MEM_W:   data = XLEN'($signed(shifted[31:0]));
      MEM_BU:  data = XLEN'(shifted[7:0]);
      MEM_HU:  data = XLEN'(shifted[15:0]);
      MEM_WU:  data = XLEN'(shifted[31:0]);
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/memory_cycle.sv
// memory_cycle: memory-access pipeline stage after execute.
//   ex_*  : instruction from execute (valid/ready handshake)
//   dmem  : data-memory bus master (request held until grant, then response)
//   wb_*  : one registered result pulse per instruction to writeback
// Faulting accesses (misaligned, illegal size, read+write) never reach the bus.
module memory_cycle
  import memory_pkg::*;
#(
  parameter int XLEN          = 64,
  parameter int FUNCT3_SIZE   = 3,
  parameter int REG_ADDR_SIZE = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ex_valid,
  output logic                     ex_ready,
  input  logic                     ex_mem_read,
  input  logic                     ex_mem_write,
  input  logic [FUNCT3_SIZE-1:0]   ex_funct3,
  input  logic [XLEN-1:0]          ex_alu_result,
  input  logic [XLEN-1:0]          ex_store_data,
  input  logic [REG_ADDR_SIZE-1:0] ex_rd,
  input  logic                     ex_reg_write,
  memory_cycle_if.master           dmem,
  output logic                     wb_valid,
  output logic [XLEN-1:0]          wb_data,
  output logic [REG_ADDR_SIZE-1:0] wb_rd,
  output logic                     wb_reg_write,
  output logic                     wb_fault
);

  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = $clog2(BE_W);

  mem_state_t state_q, state_d;

  logic [XLEN-1:0]          addr_q;
  logic [OFF_W-1:0]         off_q;
  mem_size_t                size_q;
  logic                     we_q;
  logic [BE_W-1:0]          be_q;
  logic [XLEN-1:0]          wdata_q;
  logic [REG_ADDR_SIZE-1:0] rd_q;
  logic                     reg_write_q;
  logic                     fault_q;
  logic [XLEN-1:0]          wb_data_q;

  // Decode of the presented instruction
  mem_size_t        ex_size;
  logic [OFF_W-1:0] ex_off;
  logic             ex_is_mem;
  logic             ex_fault;
  logic [7:0]       ex_be8;
  logic [XLEN-1:0]  ex_addr_aligned;
  logic [XLEN-1:0]  ex_wdata;
  logic             accept;
  logic [XLEN-1:0]  load_data;

  always_comb begin
    ex_size   = mem_size_t'(ex_funct3[2:0]);
    ex_off    = ex_alu_result[OFF_W-1:0];
    ex_is_mem = ex_mem_read | ex_mem_write;
    ex_fault  = ex_is_mem & (
                  (|(3'(ex_off) & size_align_mask(ex_size)))
                | (ex_size == MEM_ILLEGAL)
                | ((XLEN == 32) && (ex_size == MEM_D || ex_size == MEM_WU))
                | (ex_mem_read & ex_mem_write));
    ex_be8    = size_byte_mask(ex_size) << 3'(ex_off);
    ex_addr_aligned              = ex_alu_result;
    ex_addr_aligned[OFF_W-1:0]   = '0;
    ex_wdata  = ex_store_data << {ex_off, 3'b000};
    accept    = ex_valid & (state_q == IDLE);
  end

  load_data_aligner #(
    .XLEN(XLEN)
  ) u_aligner (
    .rdata  (dmem.rdata),
    .offset (off_q),
    .funct3 (size_q),
    .data   (load_data)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (ex_valid) state_d = (ex_is_mem && !ex_fault) ? REQ : RESP;
      REQ:  if (dmem.gnt) state_d = we_q ? RESP : WAIT;
      WAIT: if (dmem.rvalid) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Captured instruction and result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      off_q       <= '0;
      size_q      <= MEM_B;
      we_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      fault_q     <= 1'b0;
      wb_data_q   <= '0;
    end else if (accept) begin
      addr_q      <= ex_addr_aligned;
      off_q       <= ex_off;
      size_q      <= ex_size;
      we_q        <= ex_mem_write;
      be_q        <= BE_W'(ex_be8);
      wdata_q     <= ex_wdata;
      rd_q        <= ex_rd;
      reg_write_q <= ex_reg_write & ~ex_mem_write & ~ex_fault;
      fault_q     <= ex_fault;
      wb_data_q   <= ex_is_mem ? '0 : ex_alu_result;
    end else if (state_q == WAIT && dmem.rvalid) begin
      wb_data_q   <= load_data;
    end
  end

  // Outputs decoded from state; bus qualifiers are zero outside REQ
  always_comb begin
    ex_ready     = (state_q == IDLE);
    dmem.req     = (state_q == REQ);
    dmem.we      = (state_q == REQ) & we_q;
    dmem.be      = (state_q == REQ) ? be_q : '0;
    dmem.addr    = addr_q;
    dmem.wdata   = wdata_q;
    wb_valid     = (state_q == RESP);
    wb_data      = wb_data_q;
    wb_rd        = rd_q;
    wb_reg_write = (state_q == RESP) & reg_write_q;
    wb_fault     = (state_q == RESP) & fault_q;
  end

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for memory_cycle. Expected writeback results come from a
// byte-level model of load/store semantics; a compare process checks every
// wb_valid pulse against the queue of expected results.
module tb_memory_cycle;
  import memory_pkg::*;

  localparam int XLEN = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic        ex_mem_read = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [63:0] ex_alu_result = '0;
  logic [63:0] ex_store_data = '0;
  logic [4:0]  ex_rd = '0;
  logic        ex_reg_write = 1'b0;
  logic        wb_valid;
  logic [63:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        wb_fault;

  memory_cycle_if #(.XLEN(XLEN)) dmem ();

  memory_cycle #(
    .XLEN(XLEN),
    .FUNCT3_SIZE(3),
    .REG_ADDR_SIZE(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ex_valid(ex_valid),
    .ex_ready(ex_ready),
    .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write),
    .ex_funct3(ex_funct3),
    .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data),
    .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write),
    .dmem(dmem),
    .wb_valid(wb_valid),
    .wb_data(wb_data),
    .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write),
    .wb_fault(wb_fault)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [63:0] data;
    logic        check_data;
    logic [4:0]  rd;
    logic        rw;
    logic        fault;
  } wb_exp_t;

  wb_exp_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int size_bytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit model_fault(input logic r, input logic w, input logic [2:0] f3,
                                     input logic [63:0] a);
    if (!(r || w)) return 1'b0;
    return (f3 == 3'b111) || (r && w) || ((int'(a[2:0]) % size_bytes(f3)) != 0);
  endfunction

  function automatic logic [7:0] model_be(input logic [2:0] f3, input logic [63:0] a);
    logic [7:0] m = '0;
    for (int i = 0; i < size_bytes(f3); i++) m[int'(a[2:0]) + i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] sd, input logic [63:0] a);
    return sd << (8 * int'(a[2:0]));
  endfunction

  function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [63:0] a,
                                             input logic [63:0] word);
    logic [63:0] v = '0;
    int sz  = size_bytes(f3);
    int off = int'(a[2:0]);
    for (int i = 0; i < sz; i++) v[8*i +: 8] = word[8*(off+i) +: 8];
    if (!f3[2] && sz < 8 && v[8*sz-1])
      for (int b = 8 * sz; b < 64; b++) v[b] = 1'b1;
    return v;
  endfunction

  // ---------------- writeback compare ----------------
  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL wb_unexpected: wb_valid=1 rd=%0d, expected no result", wb_rd);
      end else begin
        wb_exp_t e;
        e = exp_q.pop_front();
        if (e.check_data) chk("wb_data", wb_data, e.data);
        chk("wb_rd", 64'(wb_rd), 64'(e.rd));
        chk("wb_reg_write", 64'(wb_reg_write), 64'(e.rw));
        chk("wb_fault", 64'(wb_fault), 64'(e.fault));
      end
    end
  end

  // ---------------- one instruction through the stage ----------------
  task automatic do_op(input string tag, input logic r, input logic w, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] sd, input logic [63:0] word,
                       input logic [4:0] rd, input logic rw, input int gdly, input int rdly,
                       input bit rst_mid);
    wb_exp_t e;
    bit mem = r || w;
    bit flt = model_fault(r, w, f3, a);

    e.fault      = flt;
    e.rd         = rd;
    e.rw         = rw && !w && !flt;
    e.check_data = !flt && !w;
    e.data       = mem ? ((r && !flt) ? model_load(f3, a, word) : '0) : a;
    if (!rst_mid) exp_q.push_back(e);

    chk({tag, "_ex_ready_idle"}, 64'(ex_ready), 64'd1);
    ex_valid = 1'b1; ex_mem_read = r; ex_mem_write = w; ex_funct3 = f3;
    ex_alu_result = a; ex_store_data = sd; ex_rd = rd; ex_reg_write = rw;
    @(negedge clk);
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    ex_funct3 = 3'($urandom); ex_alu_result = {$urandom, $urandom};
    ex_store_data = {$urandom, $urandom}; ex_rd = 5'($urandom);

    if (mem && !flt) begin
      for (int i = 0; i < gdly; i++) begin
        chk({tag, "_req_held"}, 64'(dmem.req), 64'd1);
        chk({tag, "_ex_ready_busy"}, 64'(ex_ready), 64'd0);
        dmem.rvalid = 1'b1;               // stray response while still requesting
        dmem.rdata  = {$urandom, $urandom};
        @(negedge clk);
      end
      dmem.rvalid = 1'b0;
      chk({tag, "_req"}, 64'(dmem.req), 64'd1);
      chk({tag, "_addr"}, dmem.addr, {a[63:3], 3'b000});
      chk({tag, "_be"}, 64'(dmem.be), 64'(model_be(f3, a)));
      chk({tag, "_we"}, 64'(dmem.we), 64'(w));
      if (w) chk({tag, "_wdata"}, dmem.wdata, model_wdata(sd, a));
      dmem.gnt = 1'b1;
      @(negedge clk);
      dmem.gnt = 1'b0;
      if (r) begin
        chk({tag, "_req_drop"}, 64'(dmem.req), 64'd0);
        for (int i = 0; i < rdly; i++) begin
          chk({tag, "_wb_wait"}, 64'(wb_valid), 64'd0);
          chk({tag, "_ex_ready_wait"}, 64'(ex_ready), 64'd0);
          @(negedge clk);
        end
        if (rst_mid) begin
          rst_n = 1'b0;
          #1;
          chk({tag, "_rst_ready"}, 64'(ex_ready), 64'd1);
          chk({tag, "_rst_req"}, 64'(dmem.req), 64'd0);
          chk({tag, "_rst_wb"}, 64'(wb_valid), 64'd0);
          @(negedge clk);
          rst_n = 1'b1;
          dmem.rvalid = 1'b1;
          dmem.rdata  = word;
          @(negedge clk);
          dmem.rvalid = 1'b0;
          chk({tag, "_late_rvalid_wb"}, 64'(wb_valid), 64'd0);
          chk({tag, "_late_rvalid_idle"}, 64'(ex_ready), 64'd1);
          @(negedge clk);
          chk({tag, "_late_rvalid_wb2"}, 64'(wb_valid), 64'd0);
          return;
        end
        dmem.rvalid = 1'b1;
        dmem.rdata  = word;
        @(negedge clk);
        dmem.rvalid = 1'b0;
        dmem.rdata  = {$urandom, $urandom};
      end
    end else begin
      chk({tag, "_no_req"}, 64'(dmem.req), 64'd0);
    end
    chk({tag, "_wb_valid"}, 64'(wb_valid), 64'd1);
    chk({tag, "_ex_ready_resp"}, 64'(ex_ready), 64'd0);
    @(negedge clk);
    chk({tag, "_wb_pulse_end"}, 64'(wb_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dmem.gnt    = 1'b0;
    dmem.rvalid = 1'b0;
    dmem.rdata  = '0;

    repeat (2) @(negedge clk);
    chk("rst_ex_ready", 64'(ex_ready), 64'd1);
    chk("rst_req", 64'(dmem.req), 64'd0);
    chk("rst_we", 64'(dmem.we), 64'd0);
    chk("rst_be", 64'(dmem.be), 64'd0);
    chk("rst_addr", dmem.addr, 64'd0);
    chk("rst_wdata", dmem.wdata, 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_data", wb_data, 64'd0);
    chk("rst_wb_rd", 64'(wb_rd), 64'd0);
    chk("rst_wb_reg_write", 64'(wb_reg_write), 64'd0);
    chk("rst_wb_fault", 64'(wb_fault), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Pin the model with hand-derived values
    chk("model_lb", model_load(3'b000, 64'h1003, 64'h0000_0000_8000_0000), 64'hFFFF_FFFF_FFFF_FF80);
    chk("model_lbu", model_load(3'b100, 64'h1003, 64'h0000_0000_8000_0000), 64'h80);
    chk("model_sh_be", 64'(model_be(3'b001, 64'h2006)), 64'hC0);
    chk("model_sh_wdata", model_wdata(64'hBEEF, 64'h2006), 64'hBEEF_0000_0000_0000);
    chk("model_lw_mis", 64'(model_fault(1'b1, 1'b0, 3'b010, 64'h3002)), 64'd1);

    //     tag        r     w     f3      addr          store data              rdata word              rd  rw  g  r  rst
    do_op("alu",     1'b0, 1'b0, 3'b000, 64'h1234,      '0,                     '0,                     5,  1,  0, 0, 0);
    do_op("lb",      1'b1, 1'b0, 3'b000, 64'h1003,      '0,                     64'h0000_0000_8000_0000, 7, 1,  2, 0, 0);
    do_op("lbu",     1'b1, 1'b0, 3'b100, 64'h1003,      '0,                     64'h0000_0000_8000_0000, 8, 1,  2, 1, 0);
    do_op("sh",      1'b0, 1'b1, 3'b001, 64'h2006,      64'h1234_5678_9ABC_BEEF, '0,                    9,  1,  1, 0, 0);
    do_op("lw_mis",  1'b1, 1'b0, 3'b010, 64'h3002,      '0,                     '0,                     10, 1,  0, 0, 0);
    do_op("f3_111",  1'b1, 1'b0, 3'b111, 64'h3000,      '0,                     '0,                     10, 1,  0, 0, 0);
    do_op("rw_both", 1'b1, 1'b1, 3'b011, 64'h4000,      '0,                     '0,                     10, 1,  0, 0, 0);
    do_op("ld",      1'b1, 1'b0, 3'b011, 64'h4008,      '0,                     64'h8123_4567_89AB_CDEF, 11, 1, 0, 2, 0);
    do_op("lh",      1'b1, 1'b0, 3'b001, 64'h500A,      '0,                     64'h1111_2222_8765_3333, 12, 1, 1, 0, 0);
    do_op("lhu",     1'b1, 1'b0, 3'b101, 64'h500A,      '0,                     64'h1111_2222_8765_3333, 12, 1, 0, 0, 0);
    do_op("lw",      1'b1, 1'b0, 3'b010, 64'h6004,      '0,                     64'h9ABC_DEF0_1234_5678, 13, 1, 0, 0, 0);
    do_op("lwu",     1'b1, 1'b0, 3'b110, 64'h6004,      '0,                     64'h9ABC_DEF0_1234_5678, 13, 1, 0, 1, 0);
    do_op("sb",      1'b0, 1'b1, 3'b000, 64'h7005,      64'hFFFF_FFFF_FFFF_FFA5, '0,                    14, 1,  0, 0, 0);
    do_op("sd",      1'b0, 1'b1, 3'b011, 64'h8000,      64'hDEAD_BEEF_0BAD_F00D, '0,                    15, 0,  3, 0, 0);
    do_op("sw_mis",  1'b0, 1'b1, 3'b010, 64'h8006,      64'h1,                  '0,                     16, 1,  0, 0, 0);
    do_op("alu_nrw", 1'b0, 1'b0, 3'b000, 64'h5A5A,      '0,                     '0,                     17, 0,  0, 0, 0);
    do_op("ld_rst",  1'b1, 1'b0, 3'b011, 64'h9000,      '0,                     64'h55,                 18, 1,  1, 1, 1);
    do_op("alu_post",1'b0, 1'b0, 3'b000, 64'hCAFE,      '0,                     '0,                     19, 1,  0, 0, 0);

    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL wb_outstanding: %0d results never written back, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
